// File: rtl/alu_result_checker_if.sv
// Purpose: ALU observation bus carrying one transaction per cycle into the
//          result checker, with a ready back-pressure signal.
// Signals: in_valid, op, a_in, b_in, result, zero, overflow (master -> slave),
//          in_ready (slave -> master).
interface alu_result_checker_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  // Side that observes the ALU and presents transactions
  modport master (
    output in_valid, op, a_in, b_in, result, zero, overflow,
    input  in_ready
  );

  // Checker side
  modport slave (
    input  in_valid, op, a_in, b_in, result, zero, overflow,
    output in_ready
  );
endinterface

// File: rtl/alu_result_checker.sv
// Purpose: Compares observed ALU results/flags against a reference model,
//          counting checked, mismatched and skipped (illegal opcode)
//          transactions and capturing the first mismatching transaction.
// Ports:   clk, rst_n (async active-low), clear (sync clear of everything),
//          bus (slave side of the ALU observation bus),
//          chk_count/err_count/skip_count (saturating statistics),
//          err_flag (sticky), first_err_* (first mismatch capture),
//          halted (halt state after a mismatch when HALT_ON_ERR=1).
module alu_result_checker #(
  parameter bit          HALT_ON_ERR = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  alu_result_checker_if.slave    bus,
  output logic [CNT_W-1:0]       chk_count,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       skip_count,
  output logic                   err_flag,
  output logic [2:0]             first_err_op,
  output logic [31:0]            first_err_a,
  output logic [31:0]            first_err_b,
  output logic [31:0]            first_err_result,
  output logic                   halted
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT = 3'b111;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Stage 1: captured transaction awaiting comparison
  logic              s1_valid;
  logic [OP_W-1:0]   s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] s1_result;
  logic              s1_zero;
  logic              s1_ovf;

  // Reference model outputs for the stage-1 transaction
  logic [DATA_W-1:0] exp_result;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              exp_zero;
  logic              exp_ovf;
  logic              legal;
  logic              mismatch;

  logic accept;
  logic commit;

  // Ready is low during reset, during clear and while halted
  assign bus.in_ready = rst_n && (state_q == ST_RUN) && !clear;
  assign accept       = bus.in_valid && bus.in_ready;
  // A transaction left in stage 1 when entering HALT is dropped, freezing counters
  assign commit       = s1_valid && (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALT);

  // Saturating increment shared by all statistics counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Reference ALU model
  always_comb begin
    exp_result = '0;
    exp_ovf    = 1'b0;
    legal      = 1'b1;
    sum        = s1_a + s1_b;
    diff       = s1_a - s1_b;
    case (s1_op)
      OP_AND: exp_result = s1_a & s1_b;
      OP_OR:  exp_result = s1_a | s1_b;
      OP_ADD: begin
        exp_result = sum;
        exp_ovf    = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) &&
                     (sum[DATA_W-1] != s1_a[DATA_W-1]);
      end
      OP_SUB: begin
        exp_result = diff;
        exp_ovf    = (s1_a[DATA_W-1] != s1_b[DATA_W-1]) &&
                     (diff[DATA_W-1] != s1_a[DATA_W-1]);
      end
      OP_SLT: exp_result = {(DATA_W-1)'(0), ($signed(s1_a) < $signed(s1_b))};
      default: legal = 1'b0;
    endcase
    exp_zero = (exp_result == '0);
    mismatch = legal && ((s1_result != exp_result) ||
                         (s1_zero != exp_zero) ||
                         (s1_ovf != exp_ovf));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic: HALT is left only through clear or reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (HALT_ON_ERR && commit && mismatch) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
    if (clear) state_d = ST_RUN;
  end

  // Stage-1 capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_result <= '0;
      s1_zero   <= 1'b0;
      s1_ovf    <= 1'b0;
    end else begin
      s1_valid <= accept && !clear;
      if (accept) begin
        s1_op     <= bus.op;
        s1_a      <= bus.a_in;
        s1_b      <= bus.b_in;
        s1_result <= bus.result;
        s1_zero   <= bus.zero;
        s1_ovf    <= bus.overflow;
      end
    end
  end

  // Statistics and first-error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_count        <= '0;
      err_count        <= '0;
      skip_count       <= '0;
      err_flag         <= 1'b0;
      first_err_op     <= '0;
      first_err_a      <= '0;
      first_err_b      <= '0;
      first_err_result <= '0;
    end else if (clear) begin
      chk_count        <= '0;
      err_count        <= '0;
      skip_count       <= '0;
      err_flag         <= 1'b0;
      first_err_op     <= '0;
      first_err_a      <= '0;
      first_err_b      <= '0;
      first_err_result <= '0;
    end else if (commit) begin
      if (!legal) begin
        skip_count <= sat_inc(skip_count);
      end else begin
        chk_count <= sat_inc(chk_count);
        if (mismatch) begin
          err_count <= sat_inc(err_count);
          if (!err_flag) begin
            err_flag         <= 1'b1;
            first_err_op     <= s1_op;
            first_err_a      <= s1_a;
            first_err_b      <= s1_b;
            first_err_result <= s1_result;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;

  logic clk;
  logic rst_n;
  logic clear0, clear1, clear2;

  int checks_total;
  int checks_passed;

  alu_result_checker_if bus0();
  alu_result_checker_if bus1();
  alu_result_checker_if bus2();

  logic [15:0] chk0, err0, skip0;
  logic        flag0, halted0;
  logic [2:0]  fop0;
  logic [31:0] fa0, fb0, fr0;

  logic [15:0] chk1, err1, skip1;
  logic        flag1, halted1;
  logic [2:0]  fop1;
  logic [31:0] fa1, fb1, fr1;

  logic [3:0]  chk2, err2, skip2;
  logic        flag2, halted2;
  logic [2:0]  fop2;
  logic [31:0] fa2, fb2, fr2;

  alu_result_checker dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .bus(bus0.slave),
    .chk_count(chk0), .err_count(err0), .skip_count(skip0),
    .err_flag(flag0), .first_err_op(fop0), .first_err_a(fa0),
    .first_err_b(fb0), .first_err_result(fr0), .halted(halted0)
  );

  alu_result_checker #(.HALT_ON_ERR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(bus1.slave),
    .chk_count(chk1), .err_count(err1), .skip_count(skip1),
    .err_flag(flag1), .first_err_op(fop1), .first_err_a(fa1),
    .first_err_b(fb1), .first_err_result(fr1), .halted(halted1)
  );

  alu_result_checker #(.CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .bus(bus2.slave),
    .chk_count(chk2), .err_count(err2), .skip_count(skip2),
    .err_flag(flag2), .first_err_op(fop2), .first_err_a(fa2),
    .first_err_b(fb2), .first_err_result(fr2), .halted(halted2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic z, input logic o);
    bus0.in_valid = v; bus0.op = op; bus0.a_in = a; bus0.b_in = b;
    bus0.result = r; bus0.zero = z; bus0.overflow = o;
  endtask

  task automatic set1(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic z, input logic o);
    bus1.in_valid = v; bus1.op = op; bus1.a_in = a; bus1.b_in = b;
    bus1.result = r; bus1.zero = z; bus1.overflow = o;
  endtask

  task automatic set2(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic z, input logic o);
    bus2.in_valid = v; bus2.op = op; bus2.a_in = a; bus2.b_in = b;
    bus2.result = r; bus2.zero = z; bus2.overflow = o;
  endtask

  task automatic test_reset();
    #12;
    checks_total++;
    if ({chk0, err0, skip0, flag0, halted0} !== 51'd0)
      $display("FAIL reset_counters0 got %h want 0", {chk0, err0, skip0, flag0, halted0});
    else checks_passed++;
    checks_total++;
    if ({bus0.in_ready, bus1.in_ready, bus2.in_ready} !== 3'b000)
      $display("FAIL reset_ready_low got %b want 000", {bus0.in_ready, bus1.in_ready, bus2.in_ready});
    else checks_passed++;
    checks_total++;
    if ({fop0, fa0, fb0, fr0} !== 99'd0)
      $display("FAIL reset_first_err got %h want 0", {fop0, fa0, fb0, fr0});
    else checks_passed++;
    rst_n = 1'b1;
    #1;
    checks_total++;
    if ({bus0.in_ready, bus1.in_ready, bus2.in_ready} !== 3'b111)
      $display("FAIL release_ready got %b want 111", {bus0.in_ready, bus1.in_ready, bus2.in_ready});
    else checks_passed++;
  endtask

  task automatic test_add_overflow();
    set0(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    step();
    set0(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks_total++;
    if (chk0 !== 16'd0)
      $display("FAIL add_latency chk_count got %0d want 0", chk0);
    else checks_passed++;
    step();
    checks_total++;
    if ({chk0, err0, flag0} !== {16'd1, 16'd0, 1'b0})
      $display("FAIL add_ovf chk/err/flag got %0d/%0d/%b want 1/0/0", chk0, err0, flag0);
    else checks_passed++;
  endtask

  task automatic test_sub_mismatch();
    set0(1'b1, 3'b110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
    step();
    set0(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    checks_total++;
    if ({chk0, err0, flag0} !== {16'd2, 16'd1, 1'b1})
      $display("FAIL sub_zero chk/err/flag got %0d/%0d/%b want 2/1/1", chk0, err0, flag0);
    else checks_passed++;
    checks_total++;
    if ({fop0, fa0, fb0, fr0} !== {3'b110, 32'd5, 32'd5, 32'd0})
      $display("FAIL sub_capture got %b %h %h %h want 110 5 5 0", fop0, fa0, fb0, fr0);
    else checks_passed++;
  endtask

  task automatic test_clear();
    set0(1'b1, 3'b000, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0);
    step();
    set0(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    clear0 = 1'b1;
    #1;
    checks_total++;
    if (bus0.in_ready !== 1'b0)
      $display("FAIL clear_ready got %b want 0", bus0.in_ready);
    else checks_passed++;
    step();
    clear0 = 1'b0;
    checks_total++;
    if ({chk0, err0, skip0, flag0, fop0, fa0, fb0, fr0} !== 148'd0)
      $display("FAIL clear_zero got %0d/%0d/%0d/%b op=%b", chk0, err0, skip0, flag0, fop0);
    else checks_passed++;
    step();
    checks_total++;
    if ({chk0, bus0.in_ready} !== {16'd0, 1'b1})
      $display("FAIL clear_discard chk/ready got %0d/%b want 0/1", chk0, bus0.in_ready);
    else checks_passed++;
  endtask

  task automatic test_slt_and_skip();
    set0(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    step();
    set0(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    step();
    set0(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks_total++;
    if ({chk0, err0} !== {16'd1, 16'd0})
      $display("FAIL slt_pass chk/err got %0d/%0d want 1/0", chk0, err0);
    else checks_passed++;
    step();
    checks_total++;
    if ({chk0, err0, flag0, fop0, fa0, fb0, fr0} !==
        {16'd2, 16'd1, 1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0})
      $display("FAIL slt_fail got %0d/%0d/%b op=%b a=%h r=%h", chk0, err0, flag0, fop0, fa0, fr0);
    else checks_passed++;
    set0(1'b1, 3'b100, 32'h1234, 32'h9, 32'hDEAD, 1'b1, 1'b1);
    step();
    set0(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    checks_total++;
    if ({skip0, chk0, err0} !== {16'd1, 16'd2, 16'd1})
      $display("FAIL illegal_skip skip/chk/err got %0d/%0d/%0d want 1/2/1", skip0, chk0, err0);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    set0(1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0); step();
    set0(1'b1, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0); step();
    set0(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0); step();
    set0(1'b1, 3'b110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1); step();
    set0(1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b1, 1'b0); step();
    set0(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks_total++;
    if ({chk0, err0} !== {16'd6, 16'd1})
      $display("FAIL b2b_passes chk/err got %0d/%0d want 6/1", chk0, err0);
    else checks_passed++;
    step();
    checks_total++;
    if ({chk0, err0, skip0} !== {16'd7, 16'd2, 16'd1})
      $display("FAIL b2b_final chk/err/skip got %0d/%0d/%0d want 7/2/1", chk0, err0, skip0);
    else checks_passed++;
    checks_total++;
    if ({fop0, fr0, halted0, bus0.in_ready} !== {3'b111, 32'd0, 1'b0, 1'b1})
      $display("FAIL b2b_first_kept op=%b r=%h halted=%b ready=%b want 111 0 0 1",
               fop0, fr0, halted0, bus0.in_ready);
    else checks_passed++;
  endtask

  task automatic test_halt();
    set1(1'b1, 3'b001, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0); step();
    set1(1'b1, 3'b010, 32'h1, 32'h2, 32'h4, 1'b0, 1'b0); step();
    set1(1'b1, 3'b001, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0); step();
    checks_total++;
    if ({halted1, bus1.in_ready, chk1, err1} !== {1'b1, 1'b0, 16'd2, 16'd1})
      $display("FAIL halt_enter halted/ready/chk/err got %b/%b/%0d/%0d want 1/0/2/1",
               halted1, bus1.in_ready, chk1, err1);
    else checks_passed++;
    step(); step(); step();
    checks_total++;
    if ({halted1, bus1.in_ready, chk1, err1, skip1} !== {1'b1, 1'b0, 16'd2, 16'd1, 16'd0})
      $display("FAIL halt_frozen halted/ready/chk/err got %b/%b/%0d/%0d want 1/0/2/1",
               halted1, bus1.in_ready, chk1, err1);
    else checks_passed++;
    checks_total++;
    if ({flag1, fop1, fa1, fb1, fr1} !== {1'b1, 3'b010, 32'h1, 32'h2, 32'h4})
      $display("FAIL halt_capture op=%b a=%h b=%h r=%h want 010 1 2 4", fop1, fa1, fb1, fr1);
    else checks_passed++;
    set1(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    clear1 = 1'b1;
    step();
    clear1 = 1'b0;
    #1;
    checks_total++;
    if ({halted1, bus1.in_ready, chk1, err1, flag1, fop1, fr1} !== {1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 3'd0, 32'd0})
      $display("FAIL halt_clear halted/ready/chk/err got %b/%b/%0d/%0d want 0/1/0/0",
               halted1, bus1.in_ready, chk1, err1);
    else checks_passed++;
  endtask

  task automatic test_saturate_and_async_reset();
    for (int i = 0; i < 20; i++) begin
      set2(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
    end
    set2(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    checks_total++;
    if ({chk2, err2, skip2} !== {4'd15, 4'd0, 4'd0})
      $display("FAIL saturate chk/err/skip got %0d/%0d/%0d want 15/0/0", chk2, err2, skip2);
    else checks_passed++;
    set2(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if ({chk2, err2, skip2, flag2, halted2, bus2.in_ready} !== 15'd0)
      $display("FAIL async_reset got chk=%0d ready=%b want 0/0", chk2, bus2.in_ready);
    else checks_passed++;
    checks_total++;
    if ({chk0, err0, skip0, flag0, fop0} !== 52'd0)
      $display("FAIL async_reset_dut0 got %0d/%0d/%0d", chk0, err0, skip0);
    else checks_passed++;
    set2(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step(); step();
    checks_total++;
    if ({chk2, bus2.in_ready} !== {4'd0, 1'b1})
      $display("FAIL reset_discard chk/ready got %0d/%b want 0/1", chk2, bus2.in_ready);
    else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n  = 1'b0;
    clear0 = 1'b0;
    clear1 = 1'b0;
    clear2 = 1'b0;
    set0(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    set1(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    set2(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_add_overflow();
    test_sub_mismatch();
    test_clear();
    test_slt_and_skip();
    test_back_to_back();
    test_halt();
    test_saturate_and_async_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
